alu_logic_stage: RTL

Registered execute stage for the 64-bit ALU logical path. It accepts an opcode, operands and a tag from the issue stage over a valid/ready handshake, and computes AND/OR/XOR/NOR/XNOR/NAND/NOT. Results go into a 2-entry output FIFO with zero and illegal-op flags. Writeback consumes the FIFO output over a second valid/ready handshake, so downstream stalls absorb without dropping data.

---
 rtl/alu_logic_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/alu_logic_stage.sv
// alu_logic_stage: registered execute stage for the 64-bit logical ALU path.
// Accepted ops are evaluated combinationally. Each result is written into a
// 2-entry FIFO together with its tag, a zero flag and an illegal-op flag.
// Writeback drains the FIFO over its own valid/ready handshake.
module alu_logic_stage #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_illegal
);

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NOR  = 3'b011,
    OP_XNOR = 3'b100,
    OP_NAND = 3'b101,
    OP_NOT  = 3'b110,
    OP_ILL  = 3'b111
  } op_e;

  logic [WIDTH-1:0] mem_result  [2];
  logic [TAG_W-1:0] mem_tag     [2];
  logic             mem_zero    [2];
  logic             mem_illegal [2];

  logic       head;
  logic       tail;
  logic [1:0] count;

  logic [WIDTH-1:0] calc_result;
  logic             calc_zero;
  logic             calc_illegal;
  logic             push;
  logic             pop;

  // in_ready comes only from the registered count, so a late out_ready
  // never reaches back into the issue stage in the same cycle.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Evaluate the logical op for the incoming operands. The illegal opcode
  // yields a zero result, so its zero flag is also set.
  always_comb begin
    calc_result  = '0;
    calc_illegal = 1'b0;
    case (op_e'(in_op))
      OP_AND:  calc_result = in_a & in_b;
      OP_OR:   calc_result = in_a | in_b;
      OP_XOR:  calc_result = in_a ^ in_b;
      OP_NOR:  calc_result = ~(in_a | in_b);
      OP_XNOR: calc_result = ~(in_a ^ in_b);
      OP_NAND: calc_result = ~(in_a & in_b);
      OP_NOT:  calc_result = ~in_a;
      default: calc_illegal = 1'b1;
    endcase
    calc_zero = (calc_result == '0);
  end

  // Entry storage: the tail slot captures the new op on each accepting
  // edge. Reset clears every entry so no stale data can reappear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem_result[i]  <= '0;
        mem_tag[i]     <= '0;
        mem_zero[i]    <= 1'b0;
        mem_illegal[i] <= 1'b0;
      end
    end else if (push) begin
      mem_result[tail]  <= calc_result;
      mem_tag[tail]     <= in_tag;
      mem_zero[tail]    <= calc_zero;
      mem_illegal[tail] <= calc_illegal;
    end
  end

  // Pointer and occupancy bookkeeping. A push and a pop in the same cycle
  // leave the count unchanged while both pointers advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) tail <= ~tail;
      if (pop)  head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Present the head entry, forcing all data to zero while the FIFO is empty.
  always_comb begin
    out_result  = '0;
    out_tag     = '0;
    out_zero    = 1'b0;
    out_illegal = 1'b0;
    if (out_valid) begin
      out_result  = mem_result[head];
      out_tag     = mem_tag[head];
      out_zero    = mem_zero[head];
      out_illegal = mem_illegal[head];
    end
  end

endmodule
